// File: rtl/apb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_pkg
//  Brief    : Shared types and constants for the APB4 memory completer.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_mem_pkg;

    localparam int WORD_LSB = 2;
    localparam int STRB_W   = 4;
    localparam int DATA_W   = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/apb_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_array
//  Brief    : Word RAM built from byte lanes, with per-lane write enables and a
//             registered read port that can be cleared.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STRB_W-1:0] i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rclr,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // One memory per byte lane so each maps onto a plain single-write RAM.
    for (genvar l = 0; l < STRB_W; l++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rdata;

        always_ff @(posedge clk) begin
            if (i_we[l]) begin
                r_mem[i_waddr] <= i_wdata[8*l +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (rst || i_rclr) begin
                r_rdata <= 8'h00;
            end else if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end

        assign o_rdata[8*l +: 8] = r_rdata;
    end

endmodule
`default_nettype wire

// File: rtl/apb_mem_completer.sv
`default_nettype none
// ============================================================================
//  Module   : apb_mem_completer
//  Brief    : APB4 completer memory with byte strobes and fixed wait states.
//             Define APB_MEM_SLVERR_EN to enable out-of-range / misaligned
//             PSLVERR responses; otherwise addresses wrap and never error.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_mem_completer
    import apb_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [STRB_W-1:0] pstrb,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int         c_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_strb;
    logic                r_pslverr;

    logic [ADDR_W-1:0]   w_offset;
    logic [c_IDX_W-1:0]  w_idx;
    logic                w_err;
    logic                w_setup;
    logic                w_pready;
    logic                w_commit;
    logic [STRB_W-1:0]   w_we;
    logic                w_re;
    logic                w_rclr;

    assign w_offset = paddr - BASE_ADDR;
    // Truncating the word address gives modulo-DEPTH wrap for free.
    assign w_idx    = c_IDX_W'(w_offset >> WORD_LSB);

`ifdef APB_MEM_SLVERR_EN
    localparam logic [ADDR_W:0] c_SPAN = (ADDR_W+1)'(DEPTH_WORDS * STRB_W);
    assign w_err = ({1'b0, w_offset} >= c_SPAN) || (paddr[WORD_LSB-1:0] != '0);
`else
    assign w_err = 1'b0;
`endif

    assign w_setup  = (r_state == IDLE) && psel && !penable;
    assign w_pready = (r_state == ACCESS) && (r_cnt == 4'd0);
    // A reset on the completing edge must not let the write land.
    assign w_commit = w_pready && psel && r_write && !r_pslverr && !reset;
    assign w_we     = w_commit ? r_strb : '0;
    assign w_re     = w_setup && !pwrite && !w_err && !reset;
    assign w_rclr   = w_setup && w_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (psel && !penable) begin
                        r_write   <= pwrite;
                        r_idx     <= w_idx;
                        r_wdata   <= pwdata;
                        r_strb    <= pstrb;
                        r_pslverr <= w_err;
                        r_cnt     <= c_WAIT;
                        r_state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        r_state <= IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    apb_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (c_IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_wdata),
        .i_re    (w_re),
        .i_rclr  (w_rclr),
        .i_raddr (w_idx),
        .o_rdata (prdata)
    );

    assign pready = w_pready;
`ifdef APB_MEM_SLVERR_EN
    assign pslverr = r_pslverr;
`else
    assign pslverr = 1'b0 & r_pslverr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_completer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_mem_completer
//  Brief    : Directed bench for apb_mem_completer, three instances with
//             0, 2 and 3 wait states sharing one APB bus and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mem_completer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  psel = '0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic [31:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_mem_completer #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]));

    apb_mem_completer #(.WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]));

    apb_mem_completer #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]));

    // Entered and left at posedge+1; idle_after=0 leaves the bus driven so the
    // next call can place its setup phase in the very next cycle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input bit idle_after, output logic [31:0] rdata,
                        output logic err, output int waits);
        bit done = 1'b0;
        waits = 0;
        rdata = 'x;
        err   = 1'bx;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wdata; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (pready_v[d]) begin
                done  = 1'b1;
                rdata = prdata_v[d];
                err   = pslverr_v[d];
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%h got no pready, required pready=1", d, addr);
        end
        if (idle_after) begin
            psel[d] = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (pready_v[d] !== 1'b0) begin errors++; $display("FAIL reset_pready dut=%0d got=%b required=0", d, pready_v[d]); end
            checks++;
            if (pslverr_v[d] !== 1'b0) begin errors++; $display("FAIL reset_pslverr dut=%0d got=%b required=0", d, pslverr_v[d]); end
            checks++;
            if (prdata_v[d] !== 32'h0) begin errors++; $display("FAIL reset_prdata dut=%0d got=%h required=0", d, prdata_v[d]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, rd, er, w);
        check_val("basic_wr_waits", 32'(w), 32'd0);
        check_val("basic_wr_err", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("basic_rd_waits", 32'(w), 32'd0);
        check_val("basic_rd_data", rd, 32'hDEADBEEF);
        check_val("basic_rd_err", {31'b0, er}, 32'd0);
    endtask

    task automatic test_strobe;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b1, rd, er, w);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("strobe_lane0", rd, 32'hDEADBEAA);
        xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b1, rd, er, w);
        check_val("strobe_zero_err", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("strobe_zero_data", rd, 32'hDEADBEAA);
        xfer(0, 1'b1, 32'h14, 32'h11223344, 4'b1010, 1'b1, rd, er, w);
        xfer(0, 1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, 1'b1, rd, er, w);
        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("strobe_mixed", rd, 32'h11BB33DD);
    endtask

    task automatic test_wait_states;
        logic [31:0] rd; logic er; int w;
        xfer(1, 1'b1, 32'h40, 32'h55AA1234, 4'hF, 1'b1, rd, er, w);
        check_val("wait2_wr_waits", 32'(w), 32'd2);
        xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("wait2_rd_waits", 32'(w), 32'd2);
        check_val("wait2_rd_data", rd, 32'h55AA1234);
    endtask

    task automatic test_error;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 1'b1, rd, er, w);
        xfer(0, 1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b1, rd, er, w);
`ifdef APB_MEM_SLVERR_EN
        check_val("oor_wr_err", {31'b0, er}, 32'd1);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("oor_word0_kept", rd, 32'h11111111);
        xfer(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("oor_rd_err", {31'b0, er}, 32'd1);
        check_val("oor_rd_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h12, 32'h99999999, 4'hF, 1'b1, rd, er, w);
        check_val("misaligned_wr_err", {31'b0, er}, 32'd1);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("misaligned_no_write", rd, 32'hDEADBEAA);
`else
        check_val("wrap_wr_err", {31'b0, er}, 32'd0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("wrap_word0", rd, 32'hCAFEF00D);
        xfer(0, 1'b0, 32'h12, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("unaligned_rd_err", {31'b0, er}, 32'd0);
        check_val("unaligned_rd_data", rd, 32'hDEADBEAA);
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int w;
        xfer(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 1'b1, rd, er, w);
        check_val("wait3_wr_waits", 32'(w), 32'd3);
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h20; pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_val("midrst_prdata", prdata_v[2], 32'h0);
        // psel+penable with no setup must never complete from IDLE.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("midrst_no_pready", {31'b0, pready_v[2]}, 32'd0);
        end
        @(posedge clk); #1 psel[2] = 1'b0; penable = 1'b0;
        xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("midrst_old_value", rd, 32'hA5A5A5A5);
        check_val("wait3_rd_waits", 32'(w), 32'd3);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int w;
        xfer(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b0, rd, er, w);
        xfer(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rd, er, w);
        check_val("b2b_rd_data", rd, 32'h0BADF00D);
        check_val("b2b_rd_waits", 32'(w), 32'd0);
        xfer(0, 1'b1, 32'h34, 32'hFEEDC0DE, 4'hF, 1'b0, rd, er, w);
        xfer(0, 1'b0, 32'h34, 32'h0, 4'h0, 1'b1, rd, er, w);
        check_val("b2b_rd_data2", rd, 32'hFEEDC0DE);
        psel[0] = 1'b1; penable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("idle_penable_no_pready", {31'b0, pready_v[0]}, 32'd0);
        end
        @(posedge clk); #1 psel[0] = 1'b0; penable = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_strobe;
        test_wait_states;
        test_error;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_mem_completer.md
Name: apb_mem_completer

Overview:
APB4 completer (slave) memory that answers memory transfers issued by the multicycle RISC-V core through the APB requester side of the design. It holds a word-organised RAM with byte-lane writes and a configurable number of wait states. It also returns PSLVERR for illegal accesses. It is the far end of the core's mem_en/MemWrite/data-length request path.

Parameters:
- ADDR_W, 32, APB address width.
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, at least 2).
- WAIT_CYCLES, 0, access-phase cycles with pready low before the completing cycle (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- psel  in  1  completer select
- penable  in  1  access phase indicator
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_W  byte address
- pwdata  in  32  write data
- pstrb  in  4  byte-lane write strobes; ignored on reads
- prdata  out  32  read data, valid when pready=1 and pwrite=0
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only when pready=1

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, sampled only at the rising edge of clk.
- Reset values: state=IDLE, wait counter=0, prdata=0, pready=0, pslverr=0. RAM contents are not reset.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch pwrite, paddr, pwdata, pstrb and the error flag.
  - Load the counter with WAIT_CYCLES and go to ACCESS.
  - On a read, prdata is loaded from the RAM on the same edge.
- IDLE protocol violation: psel=1 with penable=1 is ignored; stay in IDLE, pready stays 0.
- ACCESS:
  - pready = (counter==0), decoded from registers only; no combinational path from inputs.
  - While the counter is nonzero, decrement it each cycle.
  - In the pready=1 cycle, a write commits the latched pwdata to bytes whose pstrb bit is 1.
  - Return to IDLE on the next edge.
  - If psel drops during ACCESS, abort to IDLE with no commit.
- Latency: with WAIT_CYCLES=N, the transfer spends N+1 access-phase cycles; pready is high only in the last one.
- Back-to-back: a setup phase in the cycle after pready is accepted with no idle cycle. Returning to IDLE and sampling that setup happen on consecutive edges.
- Address decode: word index = (paddr - BASE_ADDR) >> 2.
- Error conditions (feature on):
  - out of range: (paddr - BASE_ADDR) >= DEPTH_WORDS*4
  - misaligned: paddr[1:0] != 0
- An errored transfer sets pslverr=1 in its pready cycle. The write is suppressed and prdata=0.
- pslverr and prdata are held stable until the next completion.
- A write with pstrb=4'b0000 completes normally and modifies no bytes.
- Reset mid-transfer: go to IDLE immediately, pready=0 next cycle, no pending write commits.

Optional Feature:
- APB_MEM_SLVERR_EN defined: error detection as above.
- APB_MEM_SLVERR_EN undefined:
  - pslverr is tied to 0.
  - The word index is taken modulo DEPTH_WORDS (address wraps).
  - paddr[1:0] is ignored.
  - Every transfer completes normally.

Decomposition:
- Package apb_mem_pkg: state enum (IDLE, ACCESS), WORD_LSB=2, STRB_W=4, DATA_W=32.
- Sub-module apb_mem_array: DEPTH_WORDS x 32 RAM with 4 byte-lane write enables and a synchronous read port.
- The FSM, address decode and error logic stay in apb_mem_completer.

Test Plan:
- WAIT_CYCLES=0, write 32'hDEADBEEF to 0x10 with pstrb=4'hF, then read 0x10: pready=1 in the first access cycle, prdata=32'hDEADBEEF, pslverr=0.
- Write 32'h000000AA to 0x10 with pstrb=4'b0001 after the previous test, then read: prdata=32'hDEADBEAA; pstrb=0 write leaves 32'hDEADBEAA.
- WAIT_CYCLES=2 read: pready=0 for 2 access cycles and 1 in the 3rd; prdata is correct only in that cycle.
- DEPTH_WORDS=1024, write to 0x1000:
  - feature on: pslverr=1, word 0 unchanged;
  - feature off: pslverr=0, word 0 is overwritten (wrap).
  - Misaligned 0x12 with feature on: pslverr=1.
- WAIT_CYCLES=3 write 32'h12345678 to 0x20, reset asserted in the 2nd access cycle: pready=0 thereafter, FSM is IDLE, a later read of 0x20 returns the old value.
- Back-to-back write 0x30 then read 0x30 with no idle cycle: the read completes with 32'h... (written value); a penable=1 without setup in IDLE produces no pready.
